ram_64: RTL and testbench

- 64-word x 16-bit register-file RAM, organised Hack-style as eight 8-word banks.
- Writes are synchronous on the rising clock edge. Reads are combinational from the current address.
- Asynchronous active-high reset clears every word.
- Serves as the general-purpose data memory building block inside the CPU/memory hierarchy.

---
 rtl/ram_64_pkg.sv | 13 +
 rtl/ram8_bank.sv | 42 ++++
 rtl/ram_64.sv | 48 ++++
 tb/tb_ram_64.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ram_64_pkg.sv
// Shared constants and types for the 64-word register-file RAM.
// Storage is built from flops so every word can be cleared by reset.
package ram_64_pkg;

    localparam int RAM_DATA_W      = 16;
    localparam int RAM_ADDR_W      = 6;
    localparam int RAM_BANK_ADDR_W = 3;

    localparam logic [RAM_DATA_W-1:0] RAM_WORD_RESET = 16'h0000;

    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : ram_64_pkg

// File: rtl/ram8_bank.sv
// Eight-word register bank: decoded write enables and a combinational read mux.
// Reset clears every word asynchronously and takes priority over a write.
module ram8_bank
    import ram_64_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [RAM_BANK_ADDR_W-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]      i_data_in,
    input  logic                       i_we,
    output logic [DATA_WIDTH-1:0]      o_data_out
);

    localparam int WORDS = 2 ** RAM_BANK_ADDR_W;

    logic [WORDS-1:0]      w_word_we;
    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    always_comb begin
        w_word_we         = '0;
        w_word_we[i_addr] = i_we;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= RAM_WORD_RESET;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (w_word_we[i]) begin
                    r_mem[i] <= i_data_in;
                end
            end
        end
    end

    assign o_data_out = r_mem[i_addr];

endmodule : ram8_bank

// File: rtl/ram_64.sv
// 64 x 16 RAM built Hack-style from eight 8-word banks.
// Upper address bits pick the bank for both write enable and read mux.
module ram_64
    import ram_64_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W,
    parameter int ADDR_WIDTH = RAM_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_we,
    output logic [DATA_WIDTH-1:0] o_data_out
);

    localparam int BANK_SEL_W = ADDR_WIDTH - RAM_BANK_ADDR_W;
    localparam int BANKS      = 2 ** BANK_SEL_W;

    logic [BANK_SEL_W-1:0]      w_bank_sel;
    logic [RAM_BANK_ADDR_W-1:0] w_word_addr;
    logic [BANKS-1:0]           w_bank_we;
    logic [DATA_WIDTH-1:0]      w_bank_out [BANKS];

    assign w_bank_sel  = i_addr[ADDR_WIDTH-1:RAM_BANK_ADDR_W];
    assign w_word_addr = i_addr[RAM_BANK_ADDR_W-1:0];

    always_comb begin
        w_bank_we             = '0;
        w_bank_we[w_bank_sel] = i_we;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram8_bank #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_addr     (w_word_addr),
            .i_data_in  (i_data_in),
            .i_we       (w_bank_we[b]),
            .o_data_out (w_bank_out[b])
        );
    end

    assign o_data_out = w_bank_out[w_bank_sel];

endmodule : ram_64

// File: tb/tb_ram_64.sv
// Directed plus randomized checks of ram_64 against a plain array model.
module tb_ram_64;
    import ram_64_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic [5:0] addr = '0;
    ram_word_t data_in = '0;
    logic      we = 1'b0;
    ram_word_t data_out;

    ram_word_t model [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_64 dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_addr     (addr),
        .i_data_in  (data_in),
        .i_we       (we),
        .o_data_out (data_out)
    );

    task automatic clear_model();
        foreach (model[i]) model[i] = 16'h0000;
    endtask

    task automatic check_rd(input logic [5:0] a, input string tag);
        addr = a;
        #1;
        checks++;
        assert (data_out === model[a]) else begin
            errors++;
            $error("FAIL %s addr=%0d observed=%h expected=%h", tag, a, data_out, model[a]);
        end
    endtask

    task automatic write_word(input logic [5:0] a, input ram_word_t d, input logic w);
        @(negedge clk);
        addr    = a;
        data_in = d;
        we      = w;
        @(posedge clk);
        if (w && !reset) model[a] = d;
        #1;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ram_word_t d;
        logic [5:0] a;
        logic w;

        clear_model();
        @(posedge clk);
        #1;
        check_rd(6'd9, "reset_held");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) check_rd(6'(i), "reset_sweep");

        write_word(6'd0, 16'hAAAA, 1'b1);
        check_rd(6'd0, "wr_addr0");
        write_word(6'd1, 16'hF0F0, 1'b1);
        check_rd(6'd1, "wr_addr1");
        check_rd(6'd0, "alias_addr0");

        write_word(6'd63, 16'h5555, 1'b1);
        write_word(6'd7,  16'h0007, 1'b1);
        write_word(6'd8,  16'h0008, 1'b1);
        check_rd(6'd63, "top_addr");
        check_rd(6'd7,  "bank_end");
        check_rd(6'd8,  "bank_start");
        check_rd(6'd0,  "keep_addr0");
        check_rd(6'd1,  "keep_addr1");

        // Read-during-write: old value before the edge, new value right after.
        @(negedge clk);
        addr = 6'd1; data_in = 16'hBEEF; we = 1'b1;
        #1;
        check_rd(6'd1, "rdw_before");
        @(posedge clk);
        model[1] = 16'hBEEF;
        #1;
        we = 1'b0;
        check_rd(6'd1, "rdw_after");

        for (int i = 0; i < 6; i++) write_word(6'(i * 11), 16'(i * 16'h1111 + 3), 1'b0);
        for (int i = 0; i < 64; i++) check_rd(6'(i), "we_low_hold");

        @(negedge clk);
        reset = 1'b1;
        clear_model();
        write_word(6'd5, 16'h1234, 1'b1);
        check_rd(6'd5, "reset_priority");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) write_word(6'(i), 16'(i), 1'b1);
        check_rd(6'd42, "fill_check");
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        check_rd(6'd63, "async_reset_noclk");
        for (int i = 0; i < 64; i++) check_rd(6'(i), "async_reset_sweep");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) write_word(6'(i), 16'(i), 1'b1);
        for (int i = 0; i < 64; i++) check_rd(6'(i), "comb_read_track");

        for (int n = 0; n < 300; n++) begin
            a = 6'($urandom_range(0, 63));
            d = 16'($urandom);
            w = 1'($urandom_range(0, 3) != 0);
            write_word(a, d, w);
            check_rd(a, "rand_same");
            check_rd(6'($urandom_range(0, 63)), "rand_other");
        end
        for (int i = 0; i < 64; i++) check_rd(6'(i), "final_sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_64
